issue_ctrl: RTL and testbench
=============================

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter IQ_DEPTH, default 8, instruction-queue entries (power of two, minimum 2).
REQ-002 Parameter STALL_CNT_BITS, default 32, width of the stall counter.
REQ-003 clk_in  input  1  single clock; all state on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low (low = reset).
REQ-005 rdy_in  input  1  global pause; low freezes all state.
REQ-006 if_valid  input  1; if_inst  input  32; if_pc  input  32: fetched instruction offered by fetch.
REQ-007 if_ready  output  1  queue can accept an instruction this cycle.
REQ-008 dec_inst  output  32; dec_pc  output  32: queue head driven to the decoder.
REQ-009 dec_valid  output  1  head is valid and the controller is in RUN.
REQ-010 op_type  input  6  decoder classification of dec_inst.
REQ-011 rob_full, rs_full, lsb_full  input  1 each: downstream resource-full flags.
REQ-012 issue_fire  output  1  head is dispatched this cycle; qualifies decoder to_rob/to_rs/to_lsb.
REQ-013 flush_in  input  1  mispredict/commit flush.
REQ-014 halted  output  1; illegal  output  1: terminal-state flags.
REQ-015 stall_cnt  output  STALL_CNT_BITS  count of stalled cycles.

Function
REQ-016 Queue is a circular FIFO with head/tail pointers of log2(IQ_DEPTH) bits that wrap modulo IQ_DEPTH, plus a count of log2(IQ_DEPTH)+1 bits.
REQ-017 if_ready = (count != IQ_DEPTH) && state != HALT, with no full-bypass: enqueue is refused when full even if a pop occurs in the same cycle.
REQ-018 Enqueue on the rising edge when rdy_in && if_valid && if_ready; the entry becomes visible at dec_inst one cycle later (no empty bypass).
REQ-019 dec_inst/dec_pc = entry at head, driven combinationally; value is don't-care when count == 0; dec_valid = (count != 0) && state == RUN.
REQ-020 LSB class = op_type in 10..17; RS class = any other op_type except 39.
REQ-021 issue_fire = rdy_in && dec_valid && op_type != 39 && !rob_full && (LSB class ? !lsb_full : !rs_full), combinational.
REQ-022 On issue_fire the head is popped on the same edge; simultaneous enqueue and pop leaves count unchanged.
REQ-023 FSM states: RUN, STALL, HALT.
REQ-024 RUN->STALL when dec_valid && !issue_fire && op_type != 39.
REQ-025 STALL->RUN when the blocking resource frees; dec_valid stays asserted in STALL so that issue_fire can occur in that same cycle.
REQ-026 RUN/STALL->HALT with illegal=1 when the valid head has op_type 39; the head is not popped and issue_fire stays 0.
REQ-027 RUN/STALL->HALT with halted=1 on the edge where op_type 38 issues (the instruction is popped normally).
REQ-028 In HALT: no enqueue, no issue; only reset leaves HALT; flush_in is ignored.
REQ-029 stall_cnt increments by 1 each rdy_in cycle with dec_valid && !issue_fire, and saturates at all-ones.
REQ-030 flush_in (rdy_in high, state != HALT) empties the queue (head = tail = count = 0) and sets state RUN; it overrides a same-cycle enqueue, and issue_fire is forced to 0 that cycle.
REQ-031 rdy_in low: pointers, count, state and stall_cnt hold; issue_fire = 0.

Reset
REQ-032 While rst_in is low: pointers, count = 0; state = RUN; halted, illegal = 0; stall_cnt = 0; issue_fire, dec_valid = 0; if_ready = 0 during reset and 1 after release.
REQ-033 Reset asserted mid-operation discards all queued instructions immediately, without waiting for a clock edge.

Structure
REQ-034 IQ_DEPTH default, OP_HALT (38), OP_ILLEGAL (39), and the LSB op range bounds (10, 17) shall be defined in the shared const.v.
REQ-035 FIFO storage and pointers shall live in one sub-module, iq_fifo; FSM, issue logic and counter stay in issue_ctrl.

Verification
REQ-036 After reset, push 3 instructions with all resources free: dec_valid rises 1 cycle after the first push, issue_fire on 3 consecutive cycles, count returns to 0.
REQ-037 Push 8 with rob_full=1: if_ready=0 after the 8th push, state STALL, stall_cnt counts 1,2,3...; release rob_full: issue_fire the same cycle.
REQ-038 Head is a load (op_type 12) with lsb_full=1 and rs_full=0: no issue; clear lsb_full: issue_fire=1.
REQ-039 Queue holds 5 entries, flush_in=1 with a simultaneous if_valid: next cycle count=0, dec_valid=0, state RUN.
REQ-040 Head op_type 39: illegal=1, head not popped, if_ready=0; op_type 38 issued: halted=1 and no further issue.
REQ-041 rdy_in=0 for 4 cycles mid-stream: all state frozen; rst_in pulsed low between clock edges: queue empty immediately.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// Shared constants and types for the issue controller: queue depth, special opcodes, FSM states.
package issue_ctrl_pkg;

    localparam int IQ_DEPTH_DEF = 8;

    localparam logic [5:0] OP_HALT    = 6'd38;
    localparam logic [5:0] OP_ILLEGAL = 6'd39;
    localparam logic [5:0] OP_LSB_LO  = 6'd10;
    localparam logic [5:0] OP_LSB_HI  = 6'd17;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } iq_entry_t;

    function automatic logic is_lsb_op(input logic [5:0] op);
        return (op >= OP_LSB_LO) && (op <= OP_LSB_HI);
    endfunction

endpackage

// File: rtl/issue_ctrl_iq_fifo.sv
// Circular instruction queue; head is combinational from storage, a push is visible one cycle later.
// Caller qualifies push/pop; flush clears pointers and count and wins over a same-cycle push.
module iq_fifo
    import issue_ctrl_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          i_flush,
    input  logic          i_push,
    input  iq_entry_t     i_push_dat,
    input  logic          i_pop,
    output iq_entry_t     o_head_dat,
    output logic [CW-1:0] o_count
);

    iq_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk_in) begin
        if (i_push && !i_flush) begin
            r_mem[r_tail] <= i_push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + AW'(1);
            if (i_pop)  r_head <= r_head + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_head];
    assign o_count    = r_count;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: dispatches the queue head in the same cycle the decoder classifies it.
// Stalls on rob/rs/lsb full; terminal HALT on halt or illegal opcode; rdy_in low freezes everything.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int IQ_DEPTH       = IQ_DEPTH_DEF,
    parameter int STALL_CNT_BITS = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      if_valid,
    input  logic [31:0]               if_inst,
    input  logic [31:0]               if_pc,
    output logic                      if_ready,
    output logic [31:0]               dec_inst,
    output logic [31:0]               dec_pc,
    output logic                      dec_valid,
    input  logic [5:0]                op_type,
    input  logic                      rob_full,
    input  logic                      rs_full,
    input  logic                      lsb_full,
    output logic                      issue_fire,
    input  logic                      flush_in,
    output logic                      halted,
    output logic                      illegal,
    output logic [STALL_CNT_BITS-1:0] stall_cnt
);

    localparam int CW = $clog2(IQ_DEPTH) + 1;

    state_t                    r_state;
    state_t                    w_nxt_state;
    logic                      r_ill_flag;
    logic                      w_nxt_ill;
    logic [STALL_CNT_BITS-1:0] r_stall_cnt;
    logic [CW-1:0]             w_count;
    iq_entry_t                 w_head;
    iq_entry_t                 w_push_dat;
    logic                      w_flush;
    logic                      w_push;
    logic                      w_is_ill;
    logic                      w_res_ok;

    assign w_push_dat = '{inst: if_inst, pc: if_pc};
    assign w_flush    = rdy_in && flush_in && (r_state != ST_HALT);
    assign w_push     = rdy_in && if_valid && if_ready && !w_flush;
    assign w_is_ill   = (op_type == OP_ILLEGAL);
    assign w_res_ok   = !rob_full && (is_lsb_op(op_type) ? !lsb_full : !rs_full);
    assign issue_fire = rdy_in && dec_valid && !w_flush && !w_is_ill && w_res_ok;

    iq_fifo #(.DEPTH(IQ_DEPTH)) u_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_flush    (w_flush),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (issue_fire),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    assign dec_inst = w_head.inst;
    assign dec_pc   = w_head.pc;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= ST_RUN;
            r_ill_flag <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_ill_flag <= w_nxt_ill;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ill   = r_ill_flag;
        if (rdy_in && (r_state != ST_HALT)) begin
            if (w_flush) begin
                w_nxt_state = ST_RUN;
            end else if (dec_valid && w_is_ill) begin
                w_nxt_state = ST_HALT;
                w_nxt_ill   = 1'b1;
            end else if (issue_fire && (op_type == OP_HALT)) begin
                w_nxt_state = ST_HALT;
            end else if (issue_fire) begin
                w_nxt_state = ST_RUN;
            end else if (dec_valid) begin
                w_nxt_state = ST_STALL;
            end
        end
    end

    // The head stays visible in STALL so a freed resource can dispatch it that same cycle.
    always_comb begin
        dec_valid = (w_count != '0) && (r_state != ST_HALT);
        if_ready  = rst_in && (w_count != CW'(IQ_DEPTH)) && (r_state != ST_HALT);
        halted    = (r_state == ST_HALT) && !r_ill_flag;
        illegal   = (r_state == ST_HALT) && r_ill_flag;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_stall_cnt <= '0;
        end else if (rdy_in && dec_valid && !issue_fire && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_BITS'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl with a scoreboard of pushed instructions checked at each dispatch.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_valid;
    logic [5:0]  op_type;
    logic        rob_full;
    logic        rs_full;
    logic        lsb_full;
    logic        issue_fire;
    logic        flush_in;
    logic        halted;
    logic        illegal;
    logic [31:0] stall_cnt;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          n_issued = 0;
    logic [63:0] sb [$];

    always #5 clk_in = ~clk_in;

    // Decoder model: the low six bits of the instruction are its class.
    assign op_type = dec_inst[5:0];

    issue_ctrl #(.IQ_DEPTH(8), .STALL_CNT_BITS(32)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .dec_inst   (dec_inst),
        .dec_pc     (dec_pc),
        .dec_valid  (dec_valid),
        .op_type    (op_type),
        .rob_full   (rob_full),
        .rs_full    (rs_full),
        .lsb_full   (lsb_full),
        .issue_fire (issue_fire),
        .flush_in   (flush_in),
        .halted     (halted),
        .illegal    (illegal),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] mk(input int k, input logic [5:0] op);
        return (32'(k) << 8) | {26'd0, op};
    endfunction

    task automatic push(input logic [31:0] inst);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = inst ^ 32'h8000_0000;
        #1;
        chk("push_if_ready", {63'd0, if_ready}, 64'd1);
        sb.push_back({if_inst, if_pc});
        tick();
        if_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (dec_valid === 1'b0) done = 1'b1;
        end
        chk(tag, {63'd0, done}, 64'd1);
    endtask

    // Dispatch monitor: every fired head must be the oldest outstanding push.
    always @(negedge clk_in) begin
        if (rst_in === 1'b1 && issue_fire === 1'b1) begin
            n_issued++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                chk("sb_head", {dec_inst, dec_pc}, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; flush_in = 1'b0;
        #3;
        chk("rst_if_ready",   {63'd0, if_ready},   64'd0);
        chk("rst_dec_valid",  {63'd0, dec_valid},  64'd0);
        chk("rst_issue_fire", {63'd0, issue_fire}, 64'd0);
        chk("rst_halted",     {63'd0, halted},     64'd0);
        chk("rst_illegal",    {63'd0, illegal},    64'd0);
        chk("rst_stall_cnt",  64'(stall_cnt),      64'd0);
        #9;
        rst_in = 1'b1;
        tick();
        chk("post_rst_if_ready", {63'd0, if_ready}, 64'd1);
        chk("post_rst_state", 64'(dut.r_state), 64'(ST_RUN));

        // Three back-to-back pushes, all resources free.
        chk("t1_no_bypass", {63'd0, dec_valid}, 64'd0);
        push(mk(1, 6'd1));
        chk("t1_dec_valid_rise", {63'd0, dec_valid}, 64'd1);
        push(mk(2, 6'd2));
        push(mk(3, 6'd3));
        tick();
        chk("t1_issued", 64'(n_issued), 64'd3);
        chk("t1_count", 64'(dut.w_count), 64'd0);
        chk("t1_dec_valid", {63'd0, dec_valid}, 64'd0);

        // Fill the queue behind a full ROB.
        rob_full = 1'b1;
        for (int k = 0; k < 8; k++) push(mk(10 + k, 6'd2));
        chk("t2_if_ready_full", {63'd0, if_ready}, 64'd0);
        chk("t2_state", 64'(dut.r_state), 64'(ST_STALL));
        chk("t2_stall_7", 64'(stall_cnt), 64'd7);
        tick();
        chk("t2_stall_8", 64'(stall_cnt), 64'd8);
        tick();
        chk("t2_stall_9", 64'(stall_cnt), 64'd9);
        rob_full = 1'b0;
        #1;
        chk("t2_fire_on_release", {63'd0, issue_fire}, 64'd1);
        chk("t2_no_full_bypass", {63'd0, if_ready}, 64'd0);
        drain("t2_drain");
        chk("t2_state_run", 64'(dut.r_state), 64'(ST_RUN));
        chk("t2_stall_hold", 64'(stall_cnt), 64'd9);
        chk("t2_issued", 64'(n_issued), 64'd11);

        // Load blocked by LSB only, then a load that ignores rs_full.
        lsb_full = 1'b1;
        push(mk(30, 6'd12));
        chk("t3_load_blocked", {63'd0, issue_fire}, 64'd0);
        tick();
        lsb_full = 1'b0;
        #1;
        chk("t3_load_fires", {63'd0, issue_fire}, 64'd1);
        tick();
        chk("t3_stall", 64'(stall_cnt), 64'd10);
        rs_full = 1'b1;
        push(mk(31, 6'd15));
        chk("t3_load_ignores_rs", {63'd0, issue_fire}, 64'd1);
        tick();
        rs_full = 1'b0;
        chk("t3_issued", 64'(n_issued), 64'd13);

        // Pause with work pending: nothing may move.
        rob_full = 1'b1;
        push(mk(40, 6'd5));
        push(mk(41, 6'd6));
        rdy_in = 1'b0; rob_full = 1'b0; if_valid = 1'b1; if_inst = mk(42, 6'd7);
        #1;
        chk("t4_fire_paused", {63'd0, issue_fire}, 64'd0);
        repeat (4) tick();
        chk("t4_stall_frozen", 64'(stall_cnt), 64'd11);
        chk("t4_count_frozen", 64'(dut.w_count), 64'd2);
        chk("t4_state_frozen", 64'(dut.r_state), 64'(ST_STALL));
        chk("t4_head_frozen", 64'(dec_inst), 64'(mk(40, 6'd5)));
        rdy_in = 1'b1; if_valid = 1'b0;
        #1;
        chk("t4_fire_resume", {63'd0, issue_fire}, 64'd1);
        drain("t4_drain");
        chk("t4_issued", 64'(n_issued), 64'd15);

        // Flush five queued entries with a competing enqueue.
        rob_full = 1'b1;
        for (int k = 0; k < 5; k++) push(mk(50 + k, 6'd9));
        flush_in = 1'b1; rob_full = 1'b0; if_valid = 1'b1; if_inst = mk(60, 6'd1);
        #1;
        chk("t5_fire_flush", {63'd0, issue_fire}, 64'd0);
        tick();
        flush_in = 1'b0; if_valid = 1'b0;
        sb.delete();
        chk("t5_count", 64'(dut.w_count), 64'd0);
        chk("t5_dec_valid", {63'd0, dec_valid}, 64'd0);
        chk("t5_state", 64'(dut.r_state), 64'(ST_RUN));
        chk("t5_stall", 64'(stall_cnt), 64'd16);
        push(mk(61, 6'd4));
        tick();
        chk("t5_issued", 64'(n_issued), 64'd16);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // Illegal opcode: terminal, head retained, flush and pushes ignored.
        push(mk(70, OP_ILLEGAL));
        chk("t6_no_fire", {63'd0, issue_fire}, 64'd0);
        tick();
        chk("t6_illegal", {63'd0, illegal}, 64'd1);
        chk("t6_halted", {63'd0, halted}, 64'd0);
        chk("t6_if_ready", {63'd0, if_ready}, 64'd0);
        chk("t6_count", 64'(dut.w_count), 64'd1);
        if_valid = 1'b1; if_inst = mk(71, 6'd1); flush_in = 1'b1;
        tick();
        if_valid = 1'b0; flush_in = 1'b0;
        chk("t6_halt_holds", 64'(dut.w_count), 64'd1);
        chk("t6_still_illegal", {63'd0, illegal}, 64'd1);

        // Reset pulsed between edges clears everything at once.
        #3;
        rst_in = 1'b0;
        #1;
        chk("t7_count_async", 64'(dut.w_count), 64'd0);
        chk("t7_illegal_async", {63'd0, illegal}, 64'd0);
        chk("t7_if_ready_rst", {63'd0, if_ready}, 64'd0);
        chk("t7_stall_async", 64'(stall_cnt), 64'd0);
        #2;
        rst_in = 1'b1;
        sb.delete();
        #1;
        chk("t7_if_ready_rel", {63'd0, if_ready}, 64'd1);
        tick();

        // Halt opcode issues normally, then nothing further dispatches.
        push(mk(80, 6'd1));
        push(mk(81, OP_HALT));
        push(mk(82, 6'd1));
        chk("t8_halted", {63'd0, halted}, 64'd1);
        chk("t8_illegal", {63'd0, illegal}, 64'd0);
        chk("t8_no_fire", {63'd0, issue_fire}, 64'd0);
        chk("t8_count", 64'(dut.w_count), 64'd1);
        chk("t8_if_ready", {63'd0, if_ready}, 64'd0);
        repeat (2) tick();
        chk("t8_issued", 64'(n_issued), 64'd18);
        chk("t8_sb_left", 64'(sb.size()), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
